ps2_key_fifo_rx: RTL and testbench
==================================

Name: ps2_key_fifo_rx

Overview:
Parametrised PS/2 keyboard receiver for the RTC controller front panel. It deglitches ps2c/ps2d and deframes 11-bit PS/2 frames with start/parity/stop checking and a frame timeout. It decodes E0 (extended) and F0 (break) prefixes into complete key events and buffers them in a FIFO. The PicoBlaze interface reads events at its own pace, so keystrokes are no longer lost between polls.

Parameters:
FILTER_LEN, 8, ps2c deglitch length in clk cycles (range 2..16)
DEPTH, 8, FIFO entries, power of two, 2..64
TIMEOUT_CYC, 100000, clk cycles without a falling edge before an open frame is abandoned

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
ps2c  in  1  PS/2 clock, asynchronous
ps2d  in  1  PS/2 data, asynchronous
rx_en  in  1  enables the start of new frames
rd_en  in  1  pop the head event; ignored when empty
clr_err  in  1  clears the sticky error flags
key_code  out  8  head event scan code
key_ext  out  1  head event had an E0 prefix
key_break  out  1  head event had an F0 prefix (release)
key_valid  out  1  FIFO not empty
fifo_count  out  $clog2(DEPTH)+1  occupancy
overflow  out  1  sticky: an event was dropped because the FIFO was full
frame_err  out  1  sticky: parity, start, stop or timeout error

Behaviour:
- Reset: clock and data in the filter/sync path are driven to 1. FSMs go to IDLE, pending flags clear, FIFO is emptied. All outputs are 0.
- Input path: ps2c and ps2d each pass a 2-FF synchroniser. Synced ps2c feeds a FILTER_LEN shift filter: the filtered clock goes 1 on all-ones and 0 on all-zeros, otherwise it holds. fall_edge is a 1-cycle tick on a filtered 1->0 transition.
- Frame FSM, IDLE:
  - fall_edge & rx_en -> sample bit 0 into the shift register, bit count=1, enter DATA.
  - fall_edge with rx_en=0 is ignored.
- Frame FSM, DATA:
  - Each fall_edge shifts in ps2d and increments the count. On the 11th bit, go to CHECK.
  - A per-frame timeout counter reloads on every fall_edge. When it reaches TIMEOUT_CYC -> IDLE, set frame_err, discard the bits.
  - Deasserting rx_en mid-frame does not abort the frame.
- Frame FSM, CHECK (one cycle):
  - Frame is valid if start=0, stop=1 and the 8 data bits plus parity have odd parity.
  - Valid -> hand the byte to the decoder. Invalid -> set frame_err, clear both pending flags. Then return to IDLE.
- Decoder:
  - Byte E0 -> ext_pend=1.
  - Byte F0 -> brk_pend=1.
  - Any other byte -> push {ext_pend, brk_pend, byte} and clear both flags.
  - E0 F0 xx is therefore an extended break.
- Latency: key_valid rises exactly 2 clk cycles after the fall_edge cycle of the stop bit (CHECK at +1, write at +2).
- FIFO (show-ahead):
  - Outputs show the head entry whenever key_valid=1. key_code, key_ext and key_break read 0 when the FIFO is empty.
  - Pointers wrap modulo DEPTH.
  - rd_en while empty: no effect.
  - Push while full with no simultaneous pop: the new event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Push and pop in the same cycle while empty: the push lands and the count becomes 1.
- Sticky flags: overflow and frame_err clear only on clr_err or reset. An error set in the same cycle as clr_err wins (the flag stays 1).

Optional Feature:
KEY_FILTER_EN: when defined, only make and break events whose code is one of 2B(F), 33(H), 2C(T), 75, 74, 6B, 72 (arrows, with or without E0) or 76(ESC) are pushed. All other codes are silently dropped after clearing the pending flags, with no overflow or error effect. When undefined, every non-prefix code is pushed.

Decomposition:
- Package ps2_pkg holds:
  - the prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - the key-code constants for F, H, T, the arrows and ESC;
  - the event typedef {ext, brk, code[7:0]};
  - the frame FSM state encoding.
- One sub-module, ps2_event_fifo: a generic DEPTH x 10 show-ahead FIFO with full/empty/count.

Test Plan:
- Send frame 1C with valid parity -> key_valid after 2 cycles; key_code=1C, ext=0, brk=0, fifo_count=1; rd_en -> count 0.
- Send E0 F0 75 -> exactly one event: code=75, ext=1, brk=1; the prefix bytes produce no entries.
- With DEPTH=4, send 5 keys without reading -> count=4, overflow=1, the first 4 codes are retained in order. clr_err -> overflow=0.
- Send frame 2B with a flipped parity bit -> no push, frame_err=1; a following valid 33 is pushed with ext=0, brk=0.
- Stop ps2c after 5 bits for TIMEOUT_CYC+10 cycles -> frame_err=1, FSM back in IDLE; the next full frame 76 is received correctly.
- With KEY_FILTER_EN, send 1C then 2C -> only 2C is queued. With rx_en=0, send 2C -> nothing is queued. Assert reset mid-frame -> all outputs 0 and the FIFO is empty.

Source files
------------

// File: rtl/ps2_key_fifo_rx_pkg.sv
// Shared types and constants for the PS/2 key receiver: prefix and key codes,
// the queued event layout and the frame FSM state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;

  localparam logic [7:0] KEY_F     = 8'h2B;
  localparam logic [7:0] KEY_H     = 8'h33;
  localparam logic [7:0] KEY_T     = 8'h2C;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_CHECK
  } frame_state_t;

  // Keys the front panel actually acts on.
  function automatic logic key_allowed(input logic [7:0] code);
    case (code)
      KEY_F, KEY_H, KEY_T, KEY_UP, KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_ESC:
        key_allowed = 1'b1;
      default:
        key_allowed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_fifo_rx_event_fifo.sv
// Generic show-ahead FIFO: head is valid whenever not empty, pop advances it.
// Push while full succeeds only when a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_fifo_rx.sv
// PS/2 keyboard receiver: deglitch, deframe, E0/F0 prefix decode, event FIFO.
// Define KEY_FILTER_EN to queue only the front-panel keys (F, H, T, arrows, ESC).
module ps2_key_fifo_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ps2c,
  input  logic                   ps2d,
  input  logic                   rx_en,
  input  logic                   rd_en,
  input  logic                   clr_err,
  output logic [7:0]             key_code,
  output logic                   key_ext,
  output logic                   key_break,
  output logic                   key_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  logic [1:0]            c_sync;
  logic [1:0]            d_sync;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_c;
  logic                  fall_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_sync    <= '1;
      d_sync    <= '1;
      filt_sr   <= '1;
      filt_c    <= 1'b1;
      fall_edge <= 1'b0;
    end else begin
      c_sync    <= {c_sync[0], ps2c};
      d_sync    <= {d_sync[0], ps2d};
      filt_sr   <= {filt_sr[FILTER_LEN-2:0], c_sync[1]};
      fall_edge <= 1'b0;
      if (&filt_sr) begin
        filt_c <= 1'b1;
      end else if (~|filt_sr) begin
        filt_c    <= 1'b0;
        fall_edge <= filt_c;
      end
    end
  end

  frame_state_t  state;
  logic [10:0]   frame_sr;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tmr;
  logic          ext_pend;
  logic          brk_pend;
  logic [7:0]    rx_byte;
  logic          frame_ok;
  logic          is_prefix;
  logic          key_pass;
  logic          push;
  logic          timeout;
  logic          check_bad;

  // frame_sr fills from the top, so after 11 bits [0]=start, [10]=stop.
  assign rx_byte   = frame_sr[8:1];
  assign frame_ok  = ~frame_sr[0] & frame_sr[10] & (^frame_sr[9:1]);
  assign is_prefix = (rx_byte == PS2_EXT) || (rx_byte == PS2_BRK);
`ifdef KEY_FILTER_EN
  assign key_pass  = key_allowed(rx_byte);
`else
  assign key_pass  = 1'b1;
`endif
  assign push      = (state == ST_CHECK) & frame_ok & ~is_prefix & key_pass;
  assign check_bad = (state == ST_CHECK) & ~frame_ok;
  assign timeout   = (state == ST_DATA) & ~fall_edge & (tmr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      frame_sr <= '0;
      bit_cnt  <= '0;
      tmr      <= '0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall_edge && rx_en) begin
            frame_sr <= {d_sync[1], frame_sr[10:1]};
            bit_cnt  <= 4'd1;
            tmr      <= TMR_LOAD;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (fall_edge) begin
            frame_sr <= {d_sync[1], frame_sr[10:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            tmr      <= TMR_LOAD;
            if (bit_cnt == 4'd10) state <= ST_CHECK;
          end else if (tmr == '0) begin
            state <= ST_IDLE;
          end else begin
            tmr <= tmr - TMR_ONE;
          end
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          if (frame_ok && rx_byte == PS2_EXT) begin
            ext_pend <= 1'b1;
          end else if (frame_ok && rx_byte == PS2_BRK) begin
            brk_pend <= 1'b1;
          end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ps2_event_t push_evt;
  ps2_event_t head_evt;
  logic [9:0] head_raw;
  logic       fifo_full;
  logic       fifo_empty;

  assign push_evt = '{ext: ext_pend, brk: brk_pend, code: rx_byte};
  assign head_evt = ps2_event_t'(head_raw);

  ps2_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_evt),
    .pop       (rd_en),
    .head      (head_raw),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign key_valid = ~fifo_empty;
  assign key_code  = fifo_empty ? 8'h00 : head_evt.code;
  assign key_ext   = fifo_empty ? 1'b0  : head_evt.ext;
  assign key_break = fifo_empty ? 1'b0  : head_evt.brk;

  // A new error in the clr_err cycle keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push && fifo_full && !rd_en) overflow <= 1'b1;
      else if (clr_err)                overflow <= 1'b0;
      if (timeout || check_bad)        frame_err <= 1'b1;
      else if (clr_err)                frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_fifo_rx.sv
// Directed bench for ps2_key_fifo_rx (DEPTH=4, short timeout); drives PS/2
// frames bit by bit and checks queued events, sticky flags and latency.
module tb_ps2_key_fifo_rx;
  import ps2_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 300;

  logic       clk;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  ps2_key_fifo_rx #(
    .FILTER_LEN  (8),
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .rx_en      (rx_en),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_break  (key_break),
    .key_valid  (key_valid),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    ps2d = b;
    repeat (10) @(negedge clk);
    ps2c = 1'b0;
    repeat (20) @(negedge clk);
    ps2c = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // mode 0: plain frame; 1: check key_valid latency; 2: pulse rd_en in the CHECK cycle
  task automatic send_frame(input logic [7:0] data, input logic flip_par, input int mode);
    logic [10:0] f;
    logic        seen;
    f = {1'b1, (~^data) ^ flip_par, data, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    ps2d = 1'b1;
    repeat (10) @(negedge clk);
    ps2c = 1'b0;
    if (mode != 0) begin
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        if (dut.fall_edge) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
        $display("FAIL stop_edge: fall_edge not seen within 40 cycles (got 0 want 1)");
        n_bad++;
      end
      if (mode == 1) begin
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b0) begin
          $display("FAIL latency_plus1: key_valid got %b want 0", key_valid); n_bad++;
        end
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b1) begin
          $display("FAIL latency_plus2: key_valid got %b want 1", key_valid); n_bad++;
        end
      end else begin
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    end
    repeat (20) @(negedge clk);
    ps2c = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({key_valid, fifo_count, key_code, key_ext, key_break, overflow, frame_err} !== 15'd0) begin
      $display("FAIL reset_outputs: got valid=%b cnt=%0d code=%h ext=%b brk=%b ovf=%b ferr=%b want all 0",
               key_valid, fifo_count, key_code, key_ext, key_break, overflow, frame_err);
      n_bad++;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (key_valid !== 1'b0 || fifo_count !== 3'd0) begin
      $display("FAIL reset_release: valid=%b cnt=%0d want 0/0", key_valid, fifo_count); n_bad++;
    end
  endtask

  task automatic test_basic();
    send_frame(8'h1C, 1'b0, 1);
    n_cmp++;
    if (key_code !== 8'h1C || key_ext !== 1'b0 || key_break !== 1'b0) begin
      $display("FAIL basic_event: got code=%h ext=%b brk=%b want 1c/0/0", key_code, key_ext, key_break);
      n_bad++;
    end
    n_cmp++;
    if (fifo_count !== 3'd1) begin
      $display("FAIL basic_count: got %0d want 1", fifo_count); n_bad++;
    end
    do_pop();
    n_cmp++;
    if (fifo_count !== 3'd0 || key_valid !== 1'b0 || key_code !== 8'h00) begin
      $display("FAIL basic_pop: cnt=%0d valid=%b code=%h want 0/0/00", fifo_count, key_valid, key_code);
      n_bad++;
    end
  endtask

  task automatic test_ext_break();
    send_frame(PS2_EXT, 1'b0, 0);
    send_frame(PS2_BRK, 1'b0, 0);
    n_cmp++;
    if (fifo_count !== 3'd0) begin
      $display("FAIL prefix_no_push: got count %0d want 0", fifo_count); n_bad++;
    end
    send_frame(8'h75, 1'b0, 0);
    n_cmp++;
    if (fifo_count !== 3'd1 || key_code !== 8'h75 || key_ext !== 1'b1 || key_break !== 1'b1) begin
      $display("FAIL ext_break: cnt=%0d code=%h ext=%b brk=%b want 1/75/1/1",
               fifo_count, key_code, key_ext, key_break);
      n_bad++;
    end
    do_pop();
    send_frame(8'h72, 1'b0, 0);
    n_cmp++;
    if (key_code !== 8'h72 || key_ext !== 1'b0 || key_break !== 1'b0) begin
      $display("FAIL pend_cleared: code=%h ext=%b brk=%b want 72/0/0", key_code, key_ext, key_break);
      n_bad++;
    end
    do_pop();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_codes [4];
    exp_codes = '{8'h33, 8'h2C, 8'h75, 8'h6B};
    send_frame(8'h2B, 1'b0, 0);
    send_frame(8'h33, 1'b0, 0);
    send_frame(8'h2C, 1'b0, 0);
    send_frame(8'h75, 1'b0, 0);
    n_cmp++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      $display("FAIL ovf_fill: cnt=%0d ovf=%b want 4/0", fifo_count, overflow); n_bad++;
    end
    send_frame(8'h74, 1'b0, 0);
    n_cmp++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1 || key_code !== 8'h2B) begin
      $display("FAIL ovf_drop: cnt=%0d ovf=%b head=%h want 4/1/2b", fifo_count, overflow, key_code);
      n_bad++;
    end
    do_clr();
    n_cmp++;
    if (overflow !== 1'b0) begin
      $display("FAIL ovf_clear: got %b want 0", overflow); n_bad++;
    end
    send_frame(8'h6B, 1'b0, 2);
    n_cmp++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      $display("FAIL full_push_pop: cnt=%0d ovf=%b want 4/0", fifo_count, overflow); n_bad++;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (key_code !== exp_codes[i]) begin
        $display("FAIL ovf_order%0d: got %h want %h", i, key_code, exp_codes[i]); n_bad++;
      end
      do_pop();
    end
    do_pop();
    n_cmp++;
    if (fifo_count !== 3'd0 || key_valid !== 1'b0) begin
      $display("FAIL pop_empty: cnt=%0d valid=%b want 0/0", fifo_count, key_valid); n_bad++;
    end
    send_frame(8'h76, 1'b0, 2);
    n_cmp++;
    if (fifo_count !== 3'd1 || key_code !== 8'h76) begin
      $display("FAIL empty_push_pop: cnt=%0d code=%h want 1/76", fifo_count, key_code); n_bad++;
    end
    do_pop();
  endtask

  task automatic test_parity();
    send_frame(PS2_EXT, 1'b0, 0);
    send_frame(8'h2B, 1'b1, 0);
    n_cmp++;
    if (fifo_count !== 3'd0 || frame_err !== 1'b1) begin
      $display("FAIL parity_err: cnt=%0d ferr=%b want 0/1", fifo_count, frame_err); n_bad++;
    end
    do_clr();
    send_frame(8'h33, 1'b0, 0);
    n_cmp++;
    if (fifo_count !== 3'd1 || key_code !== 8'h33 || key_ext !== 1'b0 || key_break !== 1'b0
        || frame_err !== 1'b0) begin
      $display("FAIL parity_recover: cnt=%0d code=%h ext=%b brk=%b ferr=%b want 1/33/0/0/0",
               fifo_count, key_code, key_ext, key_break, frame_err);
      n_bad++;
    end
    do_pop();
  endtask

  task automatic test_timeout();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (TIMEOUT + 10) @(negedge clk);
    n_cmp++;
    if (frame_err !== 1'b1 || dut.state !== ST_IDLE) begin
      $display("FAIL timeout: ferr=%b state=%0d want 1/%0d", frame_err, dut.state, ST_IDLE); n_bad++;
    end
    do_clr();
    send_frame(8'h76, 1'b0, 0);
    n_cmp++;
    if (fifo_count !== 3'd1 || key_code !== 8'h76 || frame_err !== 1'b0) begin
      $display("FAIL timeout_recover: cnt=%0d code=%h ferr=%b want 1/76/0", fifo_count, key_code, frame_err);
      n_bad++;
    end
    do_pop();
  endtask

  task automatic test_rx_en();
    rx_en = 1'b0;
    send_frame(8'h2C, 1'b0, 0);
    rx_en = 1'b1;
    n_cmp++;
    if (fifo_count !== 3'd0) begin
      $display("FAIL rx_disabled: got count %0d want 0", fifo_count); n_bad++;
    end
  endtask

  task automatic test_key_filter();
    send_frame(8'h1C, 1'b0, 0);
    send_frame(8'h2C, 1'b0, 0);
    n_cmp++;
    if (fifo_count !== 3'd1 || key_code !== 8'h2C) begin
      $display("FAIL key_filter: cnt=%0d code=%h want 1/2c", fifo_count, key_code); n_bad++;
    end
    do_pop();
  endtask

  task automatic test_reset_mid();
    send_frame(8'h2C, 1'b0, 0);
    send_frame(8'h33, 1'b1, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({key_valid, fifo_count, key_code, key_ext, key_break, overflow, frame_err} !== 15'd0) begin
      $display("FAIL reset_mid: valid=%b cnt=%0d code=%h ext=%b brk=%b ovf=%b ferr=%b want all 0",
               key_valid, fifo_count, key_code, key_ext, key_break, overflow, frame_err);
      n_bad++;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(8'h2C, 1'b0, 0);
    n_cmp++;
    if (fifo_count !== 3'd1 || key_code !== 8'h2C || frame_err !== 1'b0) begin
      $display("FAIL reset_recover: cnt=%0d code=%h ferr=%b want 1/2c/0", fifo_count, key_code, frame_err);
      n_bad++;
    end
    do_pop();
  endtask

  initial begin
    reset   = 1'b1;
    ps2c    = 1'b1;
    ps2d    = 1'b1;
    rx_en   = 1'b1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
`ifdef KEY_FILTER_EN
    test_key_filter();
`else
    test_basic();
`endif
    test_ext_break();
    test_overflow();
    test_parity();
    test_timeout();
    test_rx_en();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
